ps2_rx_frame: RTL and testbench
===============================

# ps2_rx_frame

Receive-only PS/2 device-to-host frame deserializer for the MC10 keyboard path. It synchronizes and deglitches the raw `ps2_clk`/`ps2_data` lines and shifts in 11-bit frames (start, 8 data LSB-first, odd parity, stop). It presents each good byte with a one-cycle `ready` strobe to the scan-code decoder FSM directly downstream, and flags malformed or stalled frames on `error`. It never drives the PS/2 lines.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synced samples required before the filtered `ps2_clk` level changes.
- `TIMEOUT`, default 50000: clk cycles without a filtered falling edge, while mid-frame, before the frame is aborted (1 ms at 50 MHz).
- `clk`  input  1  system clock.
- `reset`  input  1  reset, synchronous, active-high; clock clk.
- `ps2_clk`  input  1  raw keyboard clock, asynchronous, idle high.
- `ps2_data`  input  1  raw keyboard data, asynchronous, idle high.
- `rx_data`  output  8  last good byte; holds until the next good frame.
- `ready`  output  1  one-cycle strobe: `rx_data` was just updated.
- `error`  output  1  one-cycle strobe: frame rejected (bad start is ignored, not an error).

## Operation
- Both lines pass through 2-flop synchronizers; sync flops reset to 1.
- `ps2_clk` filter: a counter runs while the synced sample differs from the filtered level. It clears when the sample matches. When it reaches `FILTER_LEN` the filtered level flips and the counter clears. Filtered level resets to 1.
- Bit event: filtered level goes 1→0. Sample synced `ps2_data` in the same cycle.
- FSM states are IDLE, DATA, PARITY, STOP.
  - IDLE: on event with data=0 → DATA, bit_cnt=0. On event with data=1, stay in IDLE with no error.
  - DATA: on event, shift the bit into shift[7] and right-shift, so bits land LSB-first. bit_cnt++. After the 8th bit → PARITY.
  - PARITY: on event, `par_ok` = XOR(shift, bit) == 1, i.e. odd parity. → STOP.
  - STOP: on event, if data=1 and `par_ok`: `rx_data` ← shift and pulse `ready`. Otherwise pulse `error` and leave `rx_data` unchanged. → IDLE.
- Watchdog: the counter clears on every event and in IDLE, and increments in DATA/PARITY/STOP. At `TIMEOUT`: pulse `error`, → IDLE, discard the partial byte.
- Simultaneous timeout and event: the event wins and the watchdog clears.
- `ready` and `error` are mutually exclusive. Both are registered.
- Reset, including mid-frame: state IDLE, bit_cnt 0, shift 0, `rx_data` 0x00, `ready` 0, `error` 0, watchdog 0, filter counter 0. Bits already received are discarded. The next start bit begins a fresh frame.

## Timing
- Let cycle 0 be the first clk edge that samples the stop-bit falling edge of `ps2_clk`. The filtered edge occurs at cycle 2+`FILTER_LEN`, and `ready` is high in cycle 3+`FILTER_LEN` only. Synchronizer metastability adds ±1 cycle.
- `rx_data` is valid from the `ready` cycle. It remains stable for at least one full frame (≥ ~550 µs) because the consumer samples it one or more cycles after `ready`.
- Back-to-back frames need no gap beyond the PS/2 stop→start idle. Each good frame yields exactly one `ready`.
- PS/2 clock is 10–16.7 kHz. `FILTER_LEN` must stay below half a PS/2 low phase in clk cycles.

## Structure
- Package `ps2_pkg`: `ps2_rx_state_t` enum {IDLE, DATA, PARITY, STOP}; constants `PS2_START_BIT`=0, `PS2_STOP_BIT`=1, `PS2_DATA_BITS`=8.
- Sub-module `ps2_line_filter`: 2-flop sync, glitch counter, and falling-edge pulse, parameterized by `FILTER_LEN`. It is instantiated once for `ps2_clk`. `ps2_data` uses the bare synchronizer.

## Test plan
- Frame 0x1C, parity 0, stop 1 → one `ready` at cycle `FILTER_LEN`+3 after the stop edge, `rx_data`=0x1C, `error` never high.
- Back-to-back 0xF0 (parity 1) then 0x1C → exactly two `ready` pulses. `rx_data`=0xF0, then 0x1C.
- 0x1C with parity 1 → single `error`, no `ready`, `rx_data` retains its prior 0x1C. Same result for stop bit 0.
- 3-cycle low glitch on `ps2_clk` in IDLE and mid-frame (`FILTER_LEN`=8) → no bit counted. A following valid 0x5A → `rx_data`=0x5A.
- Stop the clock after 4 data bits → `error` exactly `TIMEOUT` cycles after the last event, state returns to IDLE. A next frame of 0x12 decodes correctly.
- Assert `reset` after 5 bits → outputs 0 and state IDLE. A fresh frame of 0x59 → `ready`, `rx_data`=0x59.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receive types and frame constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;
  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;
  localparam int   PS2_DATA_BITS = 8;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop sync, glitch filter and filtered falling-edge pulse
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_sample;
  assign w_sample = r_sync[1];
  assign o_fall   = r_fall;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_fall <= 1'b0;
      if (w_sample == r_level) r_cnt <= '0;
      else if (r_cnt == CW'(FILTER_LEN)) begin
        r_level <= w_sample;
        r_cnt   <= '0;
        r_fall  <= r_level;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host 11-bit frame receiver with parity/stop check and watchdog
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       ready,
  output logic       error
);
  localparam int WW = $clog2(TIMEOUT + 1);
  ps2_rx_state_t r_state;
  logic [1:0]    r_dsync;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par_ok;
  logic [7:0]    r_rx_data;
  logic          r_ready;
  logic          r_error;
  logic [WW-1:0] r_wdog;
  logic          w_fall;
  logic          w_bit;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .reset  (reset),
    .i_line (ps2_clk),
    .o_fall (w_fall)
  );
  assign w_bit   = r_dsync[1];
  assign rx_data = r_rx_data;
  assign ready   = r_ready;
  assign error   = r_error;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_dsync   <= 2'b11;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_ok  <= 1'b0;
      r_rx_data <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
      r_wdog    <= '0;
    end else begin
      r_dsync <= {r_dsync[0], ps2_data};
      r_ready <= 1'b0;
      r_error <= 1'b0;
      // a bit event always beats the watchdog in the same cycle
      if (w_fall) begin
        r_wdog <= '0;
        case (r_state)
          IDLE: if (w_bit == PS2_START_BIT) begin
            r_state   <= DATA;
            r_bit_cnt <= '0;
          end
          DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) r_state <= PARITY;
          end
          PARITY: begin
            r_par_ok <= ^{r_shift, w_bit};
            r_state  <= STOP;
          end
          default: begin
            if (w_bit == PS2_STOP_BIT && r_par_ok) begin
              r_rx_data <= r_shift;
              r_ready   <= 1'b1;
            end else r_error <= 1'b1;
            r_state <= IDLE;
          end
        endcase
      end else if (r_state == IDLE) r_wdog <= '0;
      else if (r_wdog == WW'(TIMEOUT - 1)) begin
        r_error   <= 1'b1;
        r_state   <= IDLE;
        r_wdog    <= '0;
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else r_wdog <= r_wdog + 1'b1;
    end
  end
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: directed frames, glitches, timeout and reset against hand-computed results
module tb_ps2_rx_frame;
  import ps2_pkg::*;
  localparam int F  = 8;
  localparam int TO = 300;
  localparam int HP = 40;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       ready;
  logic       error;
  int cyc = 0, checks = 0, errors = 0;
  int rdy_cnt = 0, err_cnt = 0, rdy_cyc = 0, err_cyc = 0, last_fall = 0;
  int r0, e0;

  ps2_rx_frame #(.FILTER_LEN(F), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_data  (rx_data),
    .ready    (ready),
    .error    (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ready) begin rdy_cnt++; rdy_cyc = cyc; end
    if (error) begin err_cnt++; err_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HP / 2);
    ps2_clk = 1'b0;
    last_fall = cyc + 1;
    wait_cyc(HP);
    ps2_clk = 1'b1;
    wait_cyc(HP / 2);
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(6);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop, input int glitch_at);
    logic [10:0] fr;
    fr = {stop, ~^d ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == glitch_at) glitch();
      send_bit(fr[i]);
    end
    ps2_data = 1'b1;
    wait_cyc(HP);
  endtask

  initial begin
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(2);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_ready", 32'(ready), 0);
    chk("reset_error", 32'(error), 0);

    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    chk("f1c_ready_cnt", rdy_cnt - r0, 1);
    chk("f1c_ready_lat", rdy_cyc, last_fall + F + 3);
    chk("f1c_rx_data", 32'(rx_data), 32'h1C);
    chk("f1c_no_error", err_cnt - e0, 0);

    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    chk("b2b_first_rx", 32'(rx_data), 32'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    chk("b2b_second_rx", 32'(rx_data), 32'h1C);
    chk("b2b_ready_cnt", rdy_cnt - r0, 2);
    chk("b2b_no_error", err_cnt - e0, 0);

    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    chk("badpar_error", err_cnt - e0, 1);
    chk("badpar_no_ready", rdy_cnt - r0, 0);
    chk("badpar_rx_hold", 32'(rx_data), 32'h1C);
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    chk("badstop_error", err_cnt - e0, 1);
    chk("badstop_no_ready", rdy_cnt - r0, 0);
    chk("badstop_rx_hold", 32'(rx_data), 32'h1C);

    r0 = rdy_cnt; e0 = err_cnt;
    glitch();
    wait_cyc(30);
    chk("glitch_idle_state", 32'(dut.r_state), 32'(IDLE));
    send_frame(8'h5A, 1'b0, 1'b1, 5);
    chk("glitch_rx_data", 32'(rx_data), 32'h5A);
    chk("glitch_ready_cnt", rdy_cnt - r0, 1);
    chk("glitch_no_error", err_cnt - e0, 0);

    r0 = rdy_cnt; e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    ps2_data = 1'b1;
    wait_cyc(TO + F + 30);
    chk("tmo_error_cnt", err_cnt - e0, 1);
    chk("tmo_error_cyc", err_cyc, last_fall + F + 3 + TO);
    chk("tmo_state_idle", 32'(dut.r_state), 32'(IDLE));
    chk("tmo_no_ready", rdy_cnt - r0, 0);
    send_frame(8'h12, 1'b0, 1'b1, -1);
    chk("tmo_next_rx", 32'(rx_data), 32'h12);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    ps2_data = 1'b1;
    reset = 1'b1;
    wait_cyc(2);
    chk("rst_mid_rx_data", 32'(rx_data), 32'h00);
    chk("rst_mid_ready", 32'(ready), 0);
    chk("rst_mid_error", 32'(error), 0);
    chk("rst_mid_state", 32'(dut.r_state), 32'(IDLE));
    reset = 1'b0;
    wait_cyc(2);
    r0 = rdy_cnt; e0 = err_cnt;
    send_frame(8'h59, 1'b0, 1'b1, -1);
    chk("rst_fresh_rx", 32'(rx_data), 32'h59);
    chk("rst_fresh_ready", rdy_cnt - r0, 1);
    chk("rst_fresh_no_error", err_cnt - e0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
